// File: rtl/uart_tx_arbiter.sv
// Shares one UART DataIn port between a FIFO-buffered CPU byte stream and a
// debug/trace byte stream, granting round-robin one byte at a time.
module uart_tx_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_valid,
    input  logic [7:0]    cpu_data,
    output logic          cpu_ready,
    input  logic          dbg_valid,
    input  logic [7:0]    dbg_data,
    output logic          dbg_ready,
    output logic          uart_valid,
    output logic [7:0]    uart_data,
    input  logic          uart_ready,
    output logic [AW:0]   cpu_count,
    output logic          ovf,
    input  logic          ovf_clr,
    output logic          busy,
    output logic          state_dbg
);

    // Handshakes: a byte moves on any rising edge where its valid and ready
    // are both high. uart_valid/uart_data stay stable until uart_ready is seen;
    // dbg_data must stay stable while dbg_valid is high; cpu_valid is a push
    // strobe that is dropped (and flagged in ovf) when cpu_ready is low.

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    grant_t        last_grant;

    logic cpu_req;
    logic push;
    logic pop;
    logic grant_cpu;
    logic grant_dbg;

    // Readiness comes from the registered count only, so a full FIFO refuses
    // a push even in the cycle it pops.
    assign cpu_ready = (count != FULL_COUNT);
    assign cpu_req   = (count != '0);
    assign push      = cpu_valid & cpu_ready;

    assign grant_cpu = (state == IDLE) & cpu_req &
                       (~dbg_valid | (last_grant == GNT_DBG));
    assign grant_dbg = (state == IDLE) & dbg_valid &
                       (~cpu_req | (last_grant == GNT_CPU));
    assign pop       = grant_cpu;

    assign dbg_ready = grant_dbg;
    assign cpu_count = count;
    assign busy      = (state == HOLD) | cpu_req;
    assign state_dbg = logic'(state);

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new overflow outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (cpu_valid & ~cpu_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            uart_valid <= 1'b0;
            uart_data  <= 8'h00;
            last_grant <= GNT_DBG;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        uart_data  <= mem[rd_ptr];
                        uart_valid <= 1'b1;
                        last_grant <= GNT_CPU;
                        state      <= HOLD;
                    end else if (grant_dbg) begin
                        uart_data  <= dbg_data;
                        uart_valid <= 1'b1;
                        last_grant <= GNT_DBG;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    // Leaving HOLD always passes through IDLE, giving one
                    // bubble cycle between bytes.
                    if (uart_ready) begin
                        uart_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    uart_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
